counter: RTL and testbench



---
 rtl/counter.sv | 45 ++++
 tb/tb_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Programmable clock divider: toggles clkout every 'limit' rising edges of clk.
// Latency: clkout is a register and changes only on rising clk edges; limit takes effect on the next edge.
// Backpressure: none. Free-running while rst is high and limit is non-zero.
//
// Ports:
//   clk    - system clock. All state updates on the rising edge.
//   rst    - synchronous active-low reset. Clears cnt and clkout and discards the count phase.
//   limit  - half-period of clkout in clk cycles (unsigned). 0 holds the divider idle with clkout low.
//   clkout - divided clock with a 50% duty cycle and a period of 2*limit cycles.
module counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] limit,
    output logic             clkout
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] limit_m1;
    logic             enabled;

    // limit_m1 is only used when limit is non-zero, so the subtraction never wraps.
    assign enabled  = (limit != '0);
    assign limit_m1 = limit - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset wins over everything, including an X or undefined limit.
            cnt    <= '0;
            clkout <= 1'b0;
        end else if (!enabled) begin
            cnt    <= '0;
            clkout <= 1'b0;
        end else if (cnt >= limit_m1) begin
            // Using >= instead of == means that lowering limit below the current
            // count forces a wrap on the next edge. cnt never runs up to 2^WIDTH.
            cnt    <= '0;
            clkout <= ~clkout;
        end else begin
            cnt    <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_counter.sv
module tb_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] limit;
    logic        clkout;

    logic        rst4;
    logic [3:0]  limit4;
    logic        clkout4;

    int passed = 0;
    int total  = 0;

    // Reference state: edges counted since the last toggle or restart, and the expected output level.
    longint m_el;
    logic   m_out;

    counter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .limit (limit),
        .clkout(clkout)
    );

    counter #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst4),
        .limit (limit4),
        .clkout(clkout4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one rising edge and update the reference from the rule in force at that edge.
    // The N-th edge after a restart toggles the output, where N is the current limit.
    // The reference then clears its count. Reset or limit==0 forces idle.
    task automatic tick();
        longint lim;
        lim = longint'(limit);
        @(posedge clk);
        if (rst !== 1'b1 || lim == 0) begin
            m_el  = 0;
            m_out = 1'b0;
        end else if (m_el + 1 >= lim) begin
            m_el  = 0;
            m_out = ~m_out;
        end else begin
            m_el = m_el + 1;
        end
        #1;
        check("model_clkout", longint'(clkout), longint'(m_out));
        check("model_cnt", longint'(dut.cnt), m_el);
    endtask

    // Count edges until clkout changes, bounded by maxe, and compare the count with exp.
    task automatic wait_toggle(input string tag, input int exp, input int maxe);
        logic old;
        int   n;
        old = clkout;
        n   = 0;
        do begin
            tick();
            n++;
        end while (clkout === old && n < maxe);
        check(tag, longint'(n), longint'(exp));
    endtask

    initial begin
        int n;
        rst    = 1'b0;
        limit  = 32'd10;
        rst4   = 1'b0;
        limit4 = 4'd15;
        m_el   = 0;
        m_out  = 1'b0;

        // Reset held for 2 edges.
        tick();
        tick();
        check("reset_clkout", longint'(clkout), 0);
        check("reset_cnt", longint'(dut.cnt), 0);

        // Release reset: rise on the 10th edge, fall on the 20th, then keep the period.
        rst = 1'b1;
        wait_toggle("first_rise_10", 10, 40);
        check("first_rise_level", longint'(clkout), 1);
        wait_toggle("first_fall_10", 10, 40);
        wait_toggle("period_10", 10, 40);

        // Disabled divider.
        limit = 32'd0;
        for (int i = 0; i < 20; i++) tick();
        check("disabled_clkout", longint'(clkout), 0);
        check("disabled_cnt", longint'(dut.cnt), 0);
        limit = 32'd10;
        wait_toggle("enable_rise_10", 10, 40);

        // Raise limit mid-count at cnt=5.
        wait_toggle("sync_up", 10, 40);
        for (int i = 0; i < 5; i++) tick();
        check("up_cnt5", longint'(dut.cnt), 5);
        limit = 32'd13;
        wait_toggle("up_first_8", 8, 40);
        wait_toggle("up_period_13", 13, 40);

        // Lower limit below the current count at cnt=9.
        for (int i = 0; i < 9; i++) tick();
        check("down_cnt9", longint'(dut.cnt), 9);
        limit = 32'd7;
        wait_toggle("down_next_edge", 1, 40);
        check("down_cnt0", longint'(dut.cnt), 0);
        wait_toggle("down_period_7", 7, 40);

        // Reset mid-operation while clkout=1 and cnt=4.
        limit = 32'd13;
        n = 0;
        while (!(clkout === 1'b1 && dut.cnt == 32'd4) && n < 100) begin
            tick();
            n++;
        end
        check("midrst_reached", longint'(n < 100), 1);
        rst   = 1'b0;
        limit = 32'd7;
        tick();
        check("midrst_clkout", longint'(clkout), 0);
        check("midrst_cnt", longint'(dut.cnt), 0);
        rst = 1'b1;
        wait_toggle("midrst_rise_7", 7, 40);
        check("midrst_rise_level", longint'(clkout), 1);

        // Corner limits.
        limit = 32'd1;
        wait_toggle("sync_l1", 1, 40);
        for (int i = 0; i < 4; i++) wait_toggle("limit1_period", 1, 10);
        limit = 32'd2;
        wait_toggle("sync_l2", 2, 40);
        for (int i = 0; i < 4; i++) wait_toggle("limit2_period", 2, 10);

        // Narrow build at its maximum limit. After release the count follows
        // edge index mod 15, and the output flips every 15 edges.
        @(negedge clk);
        rst4 = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            check("w4_cnt", longint'(dut4.cnt), longint'(i % 15));
            check("w4_clkout", longint'(clkout4), longint'((i / 15) % 2));
            check("w4_cnt_max", longint'(dut4.cnt <= 4'd14), 1);
        end

        // Random phase: resets and limit changes checked against the reference every edge.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 6) rst = 1'b0;
            else rst = 1'b1;
            if ($urandom_range(99) < 8) limit = 32'($urandom_range(20));
            tick();
        end

        // Large limit: cnt climbs but never toggles within a short window.
        rst   = 1'b1;
        limit = 32'hFFFF_FFFF;
        for (int i = 0; i < 30; i++) tick();
        check("maxlim_cnt_bound", longint'(dut.cnt < 32'hFFFF_FFFE), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
